// File: rtl/jtag_host_shifter_pkg.sv
// jtag_host_shifter_pkg: shared FSM states and sizing constants for the JTAG host shifter
package jtag_host_shifter_pkg;
  localparam int JTAG_MAX_LEN = 32;
  localparam int LEN_W = 6;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
endpackage

// File: rtl/jtag_host_shifter_if.sv
// jtag_host_shifter_if: command/response handshake bundle between a host and the shift engine
interface jtag_host_shifter_if
  import jtag_host_shifter_pkg::*;
#(
  parameter int DATA_W = JTAG_MAX_LEN
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_tms;
  logic [DATA_W-1:0] cmd_tdi;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_tdo;
  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo
  );
  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo
  );
endinterface

// File: rtl/jtag_host_shifter_sync_1bit.sv
// jtag_host_shifter_sync_1bit: two-flop synchroniser for the asynchronous tdo input
module jtag_host_shifter_sync_1bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: JTAG host shift engine driving tck/tms/tdi and capturing tdo per command
module jtag_host_shifter
  import jtag_host_shifter_pkg::*;
#(
  parameter int CLKDIV = 4,
  parameter int DATA_W = JTAG_MAX_LEN
) (
  input  logic clk,
  input  logic rst,
  jtag_host_shifter_if.slave bus,
  output logic busy,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo
);
  localparam int CW = $clog2(CLKDIV);
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] CMAX = CW'(CLKDIV - 1);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(DATA_W);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LEN_W-1:0]  len_q, idx, len_c;
  logic [DATA_W-1:0] tms_q, tdi_q, tdo_q;
  logic              tdo_sync, last_phase, last_bit;
  jtag_host_shifter_sync_1bit u_sync (.clk(clk), .rst(rst), .d(tdo), .q(tdo_sync));
  assign len_c = bus.cmd_len > LMAX ? LMAX : bus.cmd_len;
  assign last_phase = cnt == CMAX;
  assign last_bit = idx + 1'b1 == len_q;
  assign bus.cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bus.rsp_tdo = tdo_q;
  // tms_q/tdi_q hold the not-yet-driven bits, so bit 0 is always the next one out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      len_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      tdo_q <= '0;
      tck <= 1'b0;
      tms <= 1'b1;
      tdi <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.cmd_valid) begin
          state <= LOW;
          cnt <= '0;
          idx <= '0;
          len_q <= len_c;
          tms_q <= bus.cmd_tms >> 1;
          tdi_q <= bus.cmd_tdi >> 1;
          tdo_q <= '0;
          if (len_c != '0) begin
            tms <= bus.cmd_tms[0];
            tdi <= bus.cmd_tdi[0];
          end
        end
        LOW: if (len_q == '0) begin
          state <= RESP;
          bus.rsp_valid <= 1'b1;
        end else if (last_phase) begin
          state <= HIGH;
          cnt <= '0;
          tck <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HIGH: if (last_phase) begin
          tdo_q[idx[IW-1:0]] <= tdo_sync;
          cnt <= '0;
          tck <= 1'b0;
          if (last_bit) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            state <= LOW;
            idx <= idx + 1'b1;
            tms <= tms_q[0];
            tdi <= tdi_q[0];
            tms_q <= tms_q >> 1;
            tdi_q <= tdi_q >> 1;
          end
        end else cnt <= cnt + 1'b1;
        RESP: if (bus.rsp_ready) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: directed bench with a cycle-level reference model and a behavioural TAP target
module tb_jtag_host_shifter;
  import jtag_host_shifter_pkg::*;
  localparam int C = 4;
  localparam logic [31:0] IDCODE = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst, loop = 1'b1;
  logic busy, tck, tms, tdi, tdo;
  int checks = 0, errs = 0;
  jtag_host_shifter_if #(.DATA_W(32)) bus();
  jtag_host_shifter #(.CLKDIV(C), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // TAP target: 16-state controller, 5-bit IR defaulting to IDCODE, TDO updated on falling tck
  int tap_st = 0;
  logic [31:0] dr = '0;
  logic [4:0] ir = 5'd1, ir_sr = '0;
  logic tap_tdo = 1'b0;
  int tck_edges = 0;
  function automatic int tap_next(input int s, input logic t);
    case (s)
      0: return t ? 0 : 1;
      1: return t ? 2 : 1;
      2: return t ? 9 : 3;
      3, 4: return t ? 5 : 4;
      5: return t ? 8 : 6;
      6: return t ? 7 : 6;
      7: return t ? 8 : 4;
      8, 15: return t ? 2 : 1;
      9: return t ? 0 : 10;
      10, 11: return t ? 12 : 11;
      12: return t ? 15 : 13;
      13: return t ? 14 : 13;
      default: return t ? 15 : 11;
    endcase
  endfunction
  always @(posedge tck) begin
    tck_edges <= tck_edges + 1;
    case (tap_st)
      0: ir <= 5'd1;
      3: dr <= ir == 5'd1 ? IDCODE : 32'h0;
      4: dr <= {tdi, dr[31:1]};
      10: ir_sr <= 5'd1;
      11: ir_sr <= {tdi, ir_sr[4:1]};
      15: ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end
  always @(negedge tck) tap_tdo <= tap_st == 4 ? dr[0] : tap_st == 11 ? ir_sr[0] : 1'b0;
  assign tdo = loop ? tdi : tap_tdo;

  // reference model: position n (edges since accept) determines every output arithmetically
  logic m_busy = 1'b0, m_tms_h = 1'b1, m_tdi_h = 1'b0;
  int n = 0, m_len = 0, m_acc = 0, m_done = 0;
  logic [31:0] m_tmsv = '0, m_tdiv = '0, m_exp = '0, exp_next = '0;
  function automatic int clampl(input logic [5:0] l);
    return l > 6'd32 ? 32 : int'(l);
  endfunction
  function automatic int lat_of(input int l);
    return l == 0 ? 1 : 2 * C * l;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 1'b0;
      n <= 0;
      m_len <= 0;
      m_tms_h <= 1'b1;
      m_tdi_h <= 1'b0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy <= 1'b1;
        n <= 0;
        m_len <= clampl(bus.cmd_len);
        m_tmsv <= bus.cmd_tms;
        m_tdiv <= bus.cmd_tdi;
        m_exp <= exp_next;
        m_acc <= m_acc + 1;
        if (clampl(bus.cmd_len) > 0) begin
          m_tms_h <= bus.cmd_tms[clampl(bus.cmd_len) - 1];
          m_tdi_h <= bus.cmd_tdi[clampl(bus.cmd_len) - 1];
        end
      end
    end else if (n >= lat_of(m_len) && bus.rsp_ready) begin
      m_busy <= 1'b0;
      m_done <= m_done + 1;
    end else n <= n + 1;

  always @(negedge clk) begin : cmp
    int b;
    logic e_tck, e_tms, e_tdi, e_rv;
    if (rst === 1'b0) begin
      b = m_len > 0 ? (n / (2 * C) > m_len - 1 ? m_len - 1 : n / (2 * C)) : 0;
      e_tck = m_busy && n < 2 * C * m_len && (n % (2 * C)) >= C;
      e_tms = (m_busy && m_len > 0) ? m_tmsv[b] : m_tms_h;
      e_tdi = (m_busy && m_len > 0) ? m_tdiv[b] : m_tdi_h;
      e_rv = m_busy && n >= lat_of(m_len);
      chk("tck", tck, e_tck);
      chk("tms", tms, e_tms);
      chk("tdi", tdi, e_tdi);
      chk("rsp_valid", bus.rsp_valid, e_rv);
      chk("busy", busy, m_busy);
      chk("cmd_ready", bus.cmd_ready, !m_busy);
      if (e_rv) chk("rsp_tdo", bus.rsp_tdo, m_exp);
    end
  end

  task automatic issue(input logic [5:0] l, input logic [31:0] ms, input logic [31:0] di, input logic [31:0] ex);
    int a0 = m_acc;
    bus.cmd_len = l;
    bus.cmd_tms = ms;
    bus.cmd_tdi = di;
    exp_next = ex;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && m_acc == a0; i++) begin
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    chk("accepted", m_acc - a0, 1);
  endtask

  task automatic finish_rsp();
    int d0 = m_done;
    for (int i = 0; i < 400 && m_done == d0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rsp_done", m_done - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [8:0] tpat, rpat;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_len = '0;
    bus.cmd_tms = '0;
    bus.cmd_tdi = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_tdo", bus.rsp_tdo, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // single bit: low phase edges 0-3, high phase edges 4-7, response at edge 8
    tpat = 9'b0_1111_0000;
    rpat = 9'b1_0000_0000;
    issue(6'd1, 32'h0, 32'h1, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("timing_tck", tck, tpat[k-1]);
      chk("timing_rsp_valid", bus.rsp_valid, rpat[k-1]);
      if (k >= 4 && k <= 6) chk("timing_tdi", tdi, 1);
    end
    finish_rsp();
    issue(6'd4, 32'hFFFF_FFF0, 32'hFFFF_FFF5, 32'h0000_0005);
    finish_rsp();
    e0 = tck_edges;
    issue(6'd32, 32'h0, 32'hA5C3_0F96, 32'hA5C3_0F96);
    finish_rsp();
    chk("loop32_edges", tck_edges - e0, 32);
    e0 = tck_edges;
    issue(6'd40, 32'h0, 32'h1234_5678, 32'h1234_5678);
    finish_rsp();
    chk("clamp_edges", tck_edges - e0, 32);
    // backpressure: response held, a pending second command must wait for the handshake
    bus.rsp_ready = 1'b0;
    issue(6'd4, 32'h0, 32'h0000_000A, 32'h0000_000A);
    bus.cmd_len = 6'd2;
    bus.cmd_tms = 32'h0;
    bus.cmd_tdi = 32'h3;
    exp_next = 32'h3;
    bus.cmd_valid = 1'b1;
    repeat (132) @(posedge clk);
    #1;
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    chk("bp_rsp_tdo", bus.rsp_tdo, 32'h0000_000A);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after", bus.cmd_ready, 1);
    chk("bp_valid_after", bus.rsp_valid, 0);
    issue(6'd2, 32'h0, 32'h3, 32'h3);
    finish_rsp();
    // reset in the high phase of bit 3 of an 8-bit command
    issue(6'd8, 32'h0, 32'h0000_00B5, 32'h0);
    repeat (29) @(posedge clk);
    #2;
    chk("pre_rst_tck", tck, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    // TAP target tests
    loop = 1'b0;
    issue(6'd5, 32'h1F, 32'h0, 32'h0);
    finish_rsp();
    chk("tap_tlr", tap_st, 0);
    e0 = tck_edges;
    issue(6'd0, 32'h3, 32'h3, 32'h0);
    @(negedge clk);
    chk("len0_rv_n0", bus.rsp_valid, 0);
    @(negedge clk);
    chk("len0_rv_n1", bus.rsp_valid, 1);
    chk("len0_tdo", bus.rsp_tdo, 0);
    finish_rsp();
    chk("len0_edges", tck_edges - e0, 0);
    issue(6'd4, 32'h2, 32'h0, 32'h0);
    finish_rsp();
    chk("tap_shift_dr", tap_st, 4);
    issue(6'd32, 32'h0, 32'h1234_5678, IDCODE);
    finish_rsp();
    issue(6'd2, 32'h3, 32'h0, 32'h0);
    finish_rsp();
    chk("tap_update_dr", tap_st, 8);
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
